lsu_bus_master: RTL and testbench

// - RV32I load/store initiator between the execute stage and the word-organised data RAM bus.
// - Accepts one load/store per handshake and checks funct3, alignment and range.
// - Drives a word-aligned bus request with byte enables and lane-shifted write data.
// - Waits any number of cycles for iBus_Ack, then returns sign/zero-extended load data or an error flag.

---
 rtl/lsu_bus_master.sv | 161 ++++++++++++++++
 tb/tb_lsu_bus_master.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: RV32I load/store initiator for a word-organised data RAM bus.
// Validates funct3, alignment and address range at accept. Legal requests get one
// bus transfer with lane enables and lane-replicated store data. Loads return
// sign- or zero-extended data. Failed checks return an error pulse without any
// bus activity.
// Optional feature: define LSU_TIMEOUT_EN to abort a bus transfer that is not
// acknowledged within TIMEOUT_CYCLES cycles.
module lsu_bus_master #(
    parameter logic [31:0] ADDR_LIMIT     = 32'd400,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq_Valid,
    output logic        oReq_Ready,
    input  logic        iReq_WrEn,
    input  logic [2:0]  iReq_Funct3,
    input  logic [31:0] iReq_Addr,
    input  logic [31:0] iReq_WrData,
    output logic        oRsp_Valid,
    output logic [31:0] oRsp_RdData,
    output logic        oRsp_Err,
    output logic        oBus_Req,
    output logic        oBus_WrEn,
    output logic [31:0] oBus_Addr,
    output logic [3:0]  oBus_ByteEn,
    output logic [31:0] oBus_WrData,
    input  logic        iBus_Ack,
    input  logic [31:0] iBus_RdData
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_RESP_ERR} state_t;

    state_t      r_state, w_next;
    logic        r_wr_en;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wr_data, r_rd_data;

    logic        w_f3_ok, w_align_ok, w_range_ok, w_req_ok;
    logic [1:0]  w_size_m1;
    logic [32:0] w_last_byte;
    logic        w_bus, w_accept;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data, w_st_data;
    logic [3:0]  w_byte_en;

    assign w_accept = (r_state == S_IDLE) && iReq_Valid;
    assign w_bus    = (r_state == S_BUS);

    // Request legality: funct3 set, natural alignment, last byte below ADDR_LIMIT
    always_comb begin
        w_size_m1  = 2'd0;
        w_align_ok = 1'b1;
        if (iReq_WrEn) w_f3_ok = (iReq_Funct3 == 3'b000) || (iReq_Funct3 == 3'b001) ||
                                 (iReq_Funct3 == 3'b010);
        else           w_f3_ok = (iReq_Funct3 == 3'b000) || (iReq_Funct3 == 3'b001) ||
                                 (iReq_Funct3 == 3'b010) || (iReq_Funct3 == 3'b100) ||
                                 (iReq_Funct3 == 3'b101);
        case (iReq_Funct3[1:0])
            2'b01: begin w_size_m1 = 2'd1; w_align_ok = ~iReq_Addr[0];           end
            2'b10: begin w_size_m1 = 2'd3; w_align_ok = (iReq_Addr[1:0] == 2'b00); end
            default: ;
        endcase
        // 33-bit sum so an access near 0xFFFF_FFFF cannot wrap into range
        w_last_byte = {1'b0, iReq_Addr} + {31'd0, w_size_m1};
        w_range_ok  = w_last_byte < {1'b0, ADDR_LIMIT};
        w_req_ok    = w_f3_ok && w_align_ok && w_range_ok;
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       w_timeout;
    assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Cycles spent in BUS without ack; held at zero outside BUS so each entry starts fresh
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)                    r_cnt <= 8'd0;
        else if (!w_bus)             r_cnt <= 8'd0;
        else if (!iBus_Ack)          r_cnt <= r_cnt + 8'd1;
    end
`else
    logic w_timeout;
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next state; an ack in the final allowed cycle beats the timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (iReq_Valid) w_next = w_req_ok ? S_BUS : S_RESP_ERR;
            S_BUS:      if (iBus_Ack)       w_next = S_RESP;
                        else if (w_timeout) w_next = S_RESP_ERR;
            S_RESP,
            S_RESP_ERR: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Request capture at accept; read word capture on ack while in BUS
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_wr_en   <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr    <= 32'd0;
            r_wr_data <= 32'd0;
            r_rd_data <= 32'd0;
        end else begin
            if (w_accept) begin
                r_wr_en   <= iReq_WrEn;
                r_funct3  <= iReq_Funct3;
                r_addr    <= iReq_Addr;
                r_wr_data <= iReq_WrData;
            end
            if (w_bus && iBus_Ack) r_rd_data <= iBus_RdData;
        end
    end

    // Lane mapping: byte enables, replicated store data, load extraction/extension
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = r_rd_data[7:0];
            2'd1:    w_byte = r_rd_data[15:8];
            2'd2:    w_byte = r_rd_data[23:16];
            default: w_byte = r_rd_data[31:24];
        endcase
        w_half = r_addr[1] ? r_rd_data[31:16] : r_rd_data[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_ld_data = r_rd_data;
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = 32'd0;
        endcase
        case (r_funct3[1:0])
            2'b00:   begin w_byte_en = 4'b0001 << r_addr[1:0];         w_st_data = {4{r_wr_data[7:0]}};  end
            2'b01:   begin w_byte_en = r_addr[1] ? 4'b1100 : 4'b0011;  w_st_data = {2{r_wr_data[15:0]}}; end
            2'b10:   begin w_byte_en = 4'b1111;                        w_st_data = r_wr_data;            end
            default: begin w_byte_en = 4'b0000;                        w_st_data = r_wr_data;            end
        endcase
    end

    // Bus outputs are driven only in BUS so the bus idles at zero otherwise
    assign oReq_Ready  = (r_state == S_IDLE);
    assign oBus_Req    = w_bus;
    assign oBus_WrEn   = w_bus & r_wr_en;
    assign oBus_Addr   = w_bus ? {r_addr[31:2], 2'b00} : 32'd0;
    assign oBus_ByteEn = w_bus ? w_byte_en : 4'd0;
    assign oBus_WrData = w_bus ? w_st_data : 32'd0;
    assign oRsp_Valid  = (r_state == S_RESP) || (r_state == S_RESP_ERR);
    assign oRsp_Err    = (r_state == S_RESP_ERR);
    assign oRsp_RdData = ((r_state == S_RESP) && !r_wr_en) ? w_ld_data : 32'd0;

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: directed vectors; expected responses go into a scoreboard
// queue at accept and a negedge monitor pops/compares each response pulse.
module tb_lsu_bus_master;

    logic        iClk = 1'b0, iRst = 1'b1;
    logic        iReq_Valid = 1'b0, iReq_WrEn = 1'b0;
    logic [2:0]  iReq_Funct3 = 3'd0;
    logic [31:0] iReq_Addr = 32'd0, iReq_WrData = 32'd0;
    logic        oReq_Ready, oRsp_Valid, oRsp_Err;
    logic [31:0] oRsp_RdData;
    logic        oBus_Req, oBus_WrEn;
    logic [31:0] oBus_Addr, oBus_WrData;
    logic [3:0]  oBus_ByteEn;
    logic        iBus_Ack = 1'b0;
    logic [31:0] iBus_RdData = 32'd0;

    lsu_bus_master dut (
        .iClk(iClk), .iRst(iRst),
        .iReq_Valid(iReq_Valid), .oReq_Ready(oReq_Ready), .iReq_WrEn(iReq_WrEn),
        .iReq_Funct3(iReq_Funct3), .iReq_Addr(iReq_Addr), .iReq_WrData(iReq_WrData),
        .oRsp_Valid(oRsp_Valid), .oRsp_RdData(oRsp_RdData), .oRsp_Err(oRsp_Err),
        .oBus_Req(oBus_Req), .oBus_WrEn(oBus_WrEn), .oBus_Addr(oBus_Addr),
        .oBus_ByteEn(oBus_ByteEn), .oBus_WrData(oBus_WrData),
        .iBus_Ack(iBus_Ack), .iBus_RdData(iBus_RdData)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct { logic err; logic [31:0] rd; int cyc; } exp_t;
    exp_t sbq[$];
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every pulse must match the oldest expectation, including its cycle
    always @(negedge iClk) begin
        if (!iRst && oRsp_Valid) begin
            if (sbq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_rsp: got err=%b rd=%h want no response", oRsp_Err, oRsp_RdData);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_err",   {31'd0, oRsp_Err}, {31'd0, e.err});
                chk("rsp_rdata", oRsp_RdData, e.rd);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    // One request. k = ack on the k-th BUS cycle; exp_err requests must never raise oBus_Req.
    task automatic run(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] ram, input int k,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input logic [3:0] exp_be, input logic [31:0] exp_bwd);
        int a, n;
        exp_t e;
        @(negedge iClk);
        chk("ready_before", {31'd0, oReq_Ready}, 32'd1);
        iReq_Valid = 1'b1; iReq_WrEn = wr; iReq_Funct3 = f3; iReq_Addr = addr; iReq_WrData = wd;
        @(posedge iClk); #1;
        // Scramble the request inputs: they must not matter after accept
        iReq_Valid = 1'b0; iReq_WrEn = ~wr; iReq_Funct3 = 3'b011;
        iReq_Addr = 32'hFFFF_FFFD; iReq_WrData = 32'h5A5A_C3C3;
        a = cyc;
        e.err = exp_err; e.rd = exp_rd; e.cyc = exp_err ? a : a + k;
        sbq.push_back(e);
        if (exp_err) begin
            @(negedge iClk);
            chk("err_no_busreq", {31'd0, oBus_Req}, 32'd0);
        end else begin
            for (int i = 1; i <= k; i++) begin
                @(negedge iClk);
                chk("bus_req",    {31'd0, oBus_Req},    32'd1);
                chk("bus_wren",   {31'd0, oBus_WrEn},   {31'd0, wr});
                chk("bus_addr",   oBus_Addr,            {addr[31:2], 2'b00});
                chk("bus_byteen", {28'd0, oBus_ByteEn}, {28'd0, exp_be});
                chk("bus_wrdata", oBus_WrData,          exp_bwd);
                if (i == k) begin iBus_Ack = 1'b1; iBus_RdData = ram; end
                @(posedge iClk); #1;
                iBus_Ack = 1'b0; iBus_RdData = 32'hDEAD_0000 | i;
            end
        end
        n = 0;
        while (!oReq_Ready && n < 20) begin @(negedge iClk); n++; end
        chk("back_to_idle", {31'd0, oReq_Ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge iClk);
        chk("rst_ready",  {31'd0, oReq_Ready},  32'd1);
        chk("rst_rspv",   {31'd0, oRsp_Valid},  32'd0);
        chk("rst_busreq", {31'd0, oBus_Req},    32'd0);
        chk("rst_byteen", {28'd0, oBus_ByteEn}, 32'd0);
        chk("rst_rdata",  oRsp_RdData,          32'd0);
        chk("rst_addr",   oBus_Addr,            32'd0);
        iRst = 1'b0;

        //   wr    f3      addr          wdata         ram           k  err  exp_rd        be       bus_wd
        run(1'b0, 3'b000, 32'h0000_0006, 32'h0,        32'h80FF_7F01, 1, 1'b0, 32'hFFFF_FFFF, 4'b0100, 32'h0);        // LB
        run(1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_1234, 2, 1'b0, 32'h0000_8001, 4'b1100, 32'h0);        // LHU
        run(1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_1234, 1, 1'b0, 32'hFFFF_8001, 4'b1100, 32'h0);        // LH
        run(1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'h1111_1111, 1, 1'b0, 32'h0,        4'b1000, 32'hA5A5_A5A5); // SB
        run(1'b0, 3'b010, 32'h0000_0002, 32'h0,        32'h0,         1, 1'b1, 32'h0,        4'b0000, 32'h0);        // LW misaligned
        run(1'b1, 3'b010, 32'h0000_0190, 32'h1234_5678, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0);        // SW out of range
        run(1'b1, 3'b100, 32'h0000_0010, 32'h1234_5678, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0);        // store f3 100
        run(1'b0, 3'b011, 32'h0000_0010, 32'h0,        32'h0,         1, 1'b1, 32'h0,        4'b0000, 32'h0);        // load f3 011
        run(1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'h1234_5678, 5, 1'b0, 32'h1234_5678, 4'b1111, 32'h0);        // LW, 5 wait cycles
        run(1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_8000, 1, 1'b0, 32'h0000_0080, 4'b0010, 32'h0);        // LBU
        run(1'b1, 3'b001, 32'h0000_018E, 32'h1234_BEEF, 32'h0,        2, 1'b0, 32'h0,        4'b1100, 32'hBEEF_BEEF); // SH at limit
        run(1'b0, 3'b010, 32'h0000_018C, 32'h0,        32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0);        // LW last word
        run(1'b0, 3'b100, 32'h0000_018F, 32'h0,        32'hAB00_0000, 1, 1'b0, 32'h0000_00AB, 4'b1000, 32'h0);        // LBU last byte
        run(1'b0, 3'b000, 32'h0000_0190, 32'h0,        32'h0,         1, 1'b1, 32'h0,        4'b0000, 32'h0);        // LB out of range
        run(1'b0, 3'b001, 32'h0000_0005, 32'h0,        32'h0,         1, 1'b1, 32'h0,        4'b0000, 32'h0);        // LH misaligned
        run(1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,        16, 1'b0, 32'h0,       4'b1111, 32'hCAFE_F00D); // SW, ack on cycle 16

        // Ack while idle must be ignored
        @(negedge iClk);
        iBus_Ack = 1'b1; iBus_RdData = 32'h7777_7777;
        repeat (3) begin
            @(negedge iClk);
            chk("idle_ack_ready", {31'd0, oReq_Ready}, 32'd1);
        end
        iBus_Ack = 1'b0;

        // Reset while in BUS: request drops asynchronously, no response follows
        @(negedge iClk);
        iReq_Valid = 1'b1; iReq_WrEn = 1'b0; iReq_Funct3 = 3'b010; iReq_Addr = 32'h0000_0020;
        @(posedge iClk); #1;
        iReq_Valid = 1'b0;
        @(negedge iClk);
        chk("mid_busreq", {31'd0, oBus_Req}, 32'd1);
        #2 iRst = 1'b1;
        #1;
        chk("async_busreq", {31'd0, oBus_Req},   32'd0);
        chk("async_ready",  {31'd0, oReq_Ready}, 32'd1);
        @(negedge iClk);
        iRst = 1'b0;
        repeat (4) @(negedge iClk);
        chk("post_rst_ready", {31'd0, oReq_Ready}, 32'd1);

`ifdef LSU_TIMEOUT_EN
        begin
            exp_t e;
            int a;
            @(negedge iClk);
            iReq_Valid = 1'b1; iReq_WrEn = 1'b0; iReq_Funct3 = 3'b010; iReq_Addr = 32'h0000_0040;
            @(posedge iClk); #1;
            iReq_Valid = 1'b0;
            a = cyc;
            e.err = 1'b1; e.rd = 32'h0; e.cyc = a + 16;
            sbq.push_back(e);
            for (int i = 1; i <= 16; i++) begin
                @(negedge iClk);
                chk("to_busreq_held", {31'd0, oBus_Req}, 32'd1);
            end
            @(negedge iClk);
            chk("to_busreq_drop", {31'd0, oBus_Req}, 32'd0);
            repeat (2) @(negedge iClk);
        end
`endif

        repeat (3) @(negedge iClk);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
